// File: rtl/edge_debouncer_pkg.sv
// IO constants shared by the button/switch input path.
// Debounce defaults assume a 50 MHz board clock: 0.5 ms sample period, 150 samples.
package edge_debouncer_pkg;

    localparam int DEBOUNCE_SAMPLE_CNT_MAX = 25000;
    localparam int DEBOUNCE_PULSE_CNT_MAX  = 150;

endpackage

// File: rtl/sample_tick_gen.sv
// Free-running wrap counter producing a one-cycle tick every SAMPLE_CNT_MAX cycles.
// Shared by all debouncer channels; also intended for baud-rate generation.
module sample_tick_gen #(
    parameter int SAMPLE_CNT_MAX = 25000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int CNT_W = $clog2(SAMPLE_CNT_MAX) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_CNT_MAX - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CNT_ONE;
        end
    end

    assign tick = (cnt_q == CNT_LAST);

endmodule

// File: rtl/edge_debouncer.sv
// Multi-channel symmetric debouncer: synchroniser, per-channel saturating sample
// counter on a shared tick, and one-cycle rise/fall pulses aligned with the new state.
module edge_debouncer
    import edge_debouncer_pkg::*;
#(
    parameter int               WIDTH              = 1,
    parameter int               SAMPLE_CNT_MAX     = DEBOUNCE_SAMPLE_CNT_MAX,
    parameter int               PULSE_CNT_MAX      = DEBOUNCE_PULSE_CNT_MAX,
    parameter int               SYNC_STAGES        = 2,
    parameter logic [WIDTH-1:0] RESET_VALUE        = {WIDTH{1'b0}},
    parameter int               WRAPPING_CNT_WIDTH = $clog2(SAMPLE_CNT_MAX) + 1,
    parameter int               SAT_CNT_WIDTH      = $clog2(PULSE_CNT_MAX) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] glitchy_signal,
    output logic [WIDTH-1:0] debounced_signal,
    output logic [WIDTH-1:0] rise_pulse,
    output logic [WIDTH-1:0] fall_pulse,
    output logic             sample_tick
);

    if (SAMPLE_CNT_MAX < 2) begin : g_bad_sample_cnt
        $fatal(1, "edge_debouncer: SAMPLE_CNT_MAX must be >= 2");
    end
    if (PULSE_CNT_MAX < 1) begin : g_bad_pulse_cnt
        $fatal(1, "edge_debouncer: PULSE_CNT_MAX must be >= 1");
    end
    if (SYNC_STAGES < 1) begin : g_bad_sync_stages
        $fatal(1, "edge_debouncer: SYNC_STAGES must be >= 1");
    end
    if (WRAPPING_CNT_WIDTH != $clog2(SAMPLE_CNT_MAX) + 1 ||
        SAT_CNT_WIDTH != $clog2(PULSE_CNT_MAX) + 1) begin : g_bad_derived
        $fatal(1, "edge_debouncer: derived counter widths must not be overridden");
    end

    localparam logic [SAT_CNT_WIDTH-1:0] CNT_LAST = SAT_CNT_WIDTH'(PULSE_CNT_MAX - 1);
    localparam logic [SAT_CNT_WIDTH-1:0] CNT_ONE  = SAT_CNT_WIDTH'(1);

    function automatic logic [SAT_CNT_WIDTH-1:0] sat_inc(input logic [SAT_CNT_WIDTH-1:0] c);
        return (c == CNT_LAST) ? c : c + CNT_ONE;
    endfunction

    logic [WIDTH-1:0] sync_p [SYNC_STAGES];
    logic [WIDTH-1:0] sync_s;

    sample_tick_gen #(
        .SAMPLE_CNT_MAX(SAMPLE_CNT_MAX)
    ) u_tick (
        .clk  (clk),
        .rst_n(rst_n),
        .tick (sample_tick)
    );

    // Stage boundary: raw asynchronous inputs -> synchroniser chain
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_p[k] <= RESET_VALUE;
            end
        end else begin
            sync_p[0] <= glitchy_signal;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_p[k] <= sync_p[k-1];
            end
        end
    end

    assign sync_s = sync_p[SYNC_STAGES-1];

    // Stage boundary: synchronised level -> per-channel stable state and event pulses
    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        logic [SAT_CNT_WIDTH-1:0] cnt_q;
        logic                     deb_q;
        logic                     rise_q;
        logic                     fall_q;

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                cnt_q  <= '0;
                deb_q  <= RESET_VALUE[i];
                rise_q <= 1'b0;
                fall_q <= 1'b0;
            end else begin
                rise_q <= 1'b0;
                fall_q <= 1'b0;
                if (sync_s[i] == deb_q) begin
                    cnt_q <= '0;
                end else if (sample_tick) begin
                    if (cnt_q == CNT_LAST) begin
                        deb_q  <= sync_s[i];
                        cnt_q  <= '0;
                        rise_q <= sync_s[i];
                        fall_q <= ~sync_s[i];
                    end else begin
                        cnt_q <= sat_inc(cnt_q);
                    end
                end
            end
        end

        assign debounced_signal[i] = deb_q;
        assign rise_pulse[i]       = rise_q;
        assign fall_pulse[i]       = fall_q;
    end

endmodule

// File: tb/tb_edge_debouncer.sv
// Scoreboard bench for edge_debouncer: two instances (reset value 0000 and 1111) driven by
// directed then random stimulus, compared every cycle against a behavioural model.
module tb_edge_debouncer;

    localparam int W  = 4;
    localparam int S  = 4;
    localparam int P  = 3;
    localparam int SY = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n0, rst_n1;
    logic [3:0] g0, g1;
    logic [3:0] deb0, rise0, fall0, deb1, rise1, fall1;
    logic       tick0, tick1;

    edge_debouncer #(
        .WIDTH(W), .SAMPLE_CNT_MAX(S), .PULSE_CNT_MAX(P), .SYNC_STAGES(SY),
        .RESET_VALUE(4'b0000)
    ) u_dut0 (
        .clk(clk), .rst_n(rst_n0), .glitchy_signal(g0),
        .debounced_signal(deb0), .rise_pulse(rise0), .fall_pulse(fall0),
        .sample_tick(tick0)
    );

    edge_debouncer #(
        .WIDTH(W), .SAMPLE_CNT_MAX(S), .PULSE_CNT_MAX(P), .SYNC_STAGES(SY),
        .RESET_VALUE(4'b1111)
    ) u_dut1 (
        .clk(clk), .rst_n(rst_n1), .glitchy_signal(g1),
        .debounced_signal(deb1), .rise_pulse(rise1), .fall_pulse(fall1),
        .sample_tick(tick1)
    );

    typedef struct {
        int         inst;
        int         cyc;
        logic [3:0] deb;
        logic [3:0] rise;
        logic [3:0] fall;
        logic       tick;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;

    // Behavioural model state: input history, stable level, sample counts, cycles since reset
    logic [3:0] m_rv   [2];
    logic [3:0] m_hist [2][SY];
    logic [3:0] m_deb  [2];
    logic [3:0] m_rise [2];
    logic [3:0] m_fall [2];
    int         m_cnt  [2][W];
    int         m_n    [2];

    task automatic model_edge(input int k, input logic rn, input logic [3:0] g);
        logic [3:0] s;
        logic       tk;
        if (!rn) begin
            for (int j = 0; j < SY; j++) m_hist[k][j] = m_rv[k];
            m_deb[k]  = m_rv[k];
            m_rise[k] = 4'b0;
            m_fall[k] = 4'b0;
            for (int c = 0; c < W; c++) m_cnt[k][c] = 0;
            m_n[k] = 0;
        end else begin
            tk = ((m_n[k] % S) == S - 1);
            s  = m_hist[k][SY-1];
            m_rise[k] = 4'b0;
            m_fall[k] = 4'b0;
            for (int c = 0; c < W; c++) begin
                if (s[c] == m_deb[k][c]) begin
                    m_cnt[k][c] = 0;
                end else if (tk) begin
                    if (m_cnt[k][c] + 1 == P) begin
                        m_deb[k][c] = s[c];
                        m_cnt[k][c] = 0;
                        if (s[c]) m_rise[k][c] = 1'b1;
                        else      m_fall[k][c] = 1'b1;
                    end else begin
                        m_cnt[k][c] = m_cnt[k][c] + 1;
                    end
                end
            end
            for (int j = SY - 1; j > 0; j--) m_hist[k][j] = m_hist[k][j-1];
            m_hist[k][0] = g;
            m_n[k] = m_n[k] + 1;
        end
    endtask

    task automatic step(input logic rn0n, input logic [3:0] g0n,
                        input logic rn1n, input logic [3:0] g1n);
        exp_t e;
        @(posedge clk);
        #1;
        model_edge(0, rst_n0, g0);
        model_edge(1, rst_n1, g1);
        for (int k = 0; k < 2; k++) begin
            e.inst = k;
            e.cyc  = cyc;
            e.deb  = m_deb[k];
            e.rise = m_rise[k];
            e.fall = m_fall[k];
            e.tick = ((m_n[k] % S) == S - 1);
            sb_q.push_back(e);
        end
        cyc++;
        rst_n0 = rn0n;
        g0     = g0n;
        rst_n1 = rn1n;
        g1     = g1n;
    endtask

    task automatic cmp(input string name, input int inst, input int c,
                       input logic [3:0] act, input logic [3:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            if (n_bad <= 40)
                $display("FAIL %s inst%0d cycle %0d: got %b expected %b", name, inst, c, act, want);
        end
    endtask

    // Monitor: the DUT presents outputs every cycle; check each pushed expectation mid-cycle
    always @(negedge clk) begin
        exp_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            if (e.inst == 0) begin
                cmp("debounced", 0, e.cyc, deb0, e.deb);
                cmp("rise_pulse", 0, e.cyc, rise0, e.rise);
                cmp("fall_pulse", 0, e.cyc, fall0, e.fall);
                cmp("sample_tick", 0, e.cyc, {3'b0, tick0}, {3'b0, e.tick});
            end else begin
                cmp("debounced", 1, e.cyc, deb1, e.deb);
                cmp("rise_pulse", 1, e.cyc, rise1, e.rise);
                cmp("fall_pulse", 1, e.cyc, fall1, e.fall);
                cmp("sample_tick", 1, e.cyc, {3'b0, tick1}, {3'b0, e.tick});
            end
        end
    end

    initial begin
        logic       nrn0, nrn1;
        logic [3:0] ng0, ng1;
        m_rv[0] = 4'b0000;
        m_rv[1] = 4'b1111;
        rst_n0 = 1'b0;
        rst_n1 = 1'b0;
        g0 = 4'b0000;
        g1 = 4'b1111;

        // Directed scenarios: reset, step, bounce, fast toggle, paired rise, mid-count reset
        for (int i = 0; i < 160; i++) begin
            nrn0 = (i >= 2);
            if      (i < 18)  ng0 = 4'b0000;
            else if (i < 38)  ng0 = 4'b0001;
            else if (i < 44)  ng0 = 4'b0000;
            else if (i < 45)  ng0 = 4'b0001;
            else if (i < 70)  ng0 = 4'b0000;
            else if (i < 130) ng0 = (((i - 70) / 3) % 2 != 0) ? 4'b0010 : 4'b0000;
            else              ng0 = 4'b1100;
            nrn1 = !(i < 2 || i == 24);
            ng1  = (i >= 20 && i < 46) ? 4'b1110 : 4'b1111;
            step(nrn0, ng0, nrn1, ng1);
        end

        // Random bouncing inputs with occasional resets
        for (int i = 0; i < 2000; i++) begin
            ng0 = g0;
            ng1 = g1;
            if ($urandom_range(0, 7) == 0) ng0[$urandom_range(0, 3)] = ~ng0[$urandom_range(0, 3)];
            if ($urandom_range(0, 7) == 0) ng1[$urandom_range(0, 3)] = ~ng1[$urandom_range(0, 3)];
            nrn0 = ($urandom_range(0, 299) != 0);
            nrn1 = ($urandom_range(0, 299) != 0);
            step(nrn0, ng0, nrn1, ng1);
        end

        for (int i = 0; i < 20; i++) step(1'b1, g0, 1'b1, g1);

        @(negedge clk);
        #1;
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
